fpu_mem_responder: RTL and testbench



---
 rtl/fpu_mem_pkg.sv | 33 +++
 rtl/fpu_mem_array.sv | 39 +++
 rtl/fpu_mem_responder.sv | 146 ++++++++++++++
 tb/tb_fpu_mem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mem_pkg.sv
// Shared types for the FPU memory responder: FSM states, error causes and
// latency-counter sizing. Optional macro FPU_MEM_RESP_JITTER_EN widens the
// counter and provides the jitter LFSR step function.
package fpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Latched with each request so the failure reason is visible on waveforms.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE,
    ERR_BOTH_OP
  } err_e;

`ifdef FPU_MEM_RESP_JITTER_EN
  // LATENCY-1 (max 14) plus up to 3 jitter cycles.
  localparam int CNT_W = 6;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`else
  localparam int CNT_W = 4;
`endif

endpackage

// File: rtl/fpu_mem_array.sv
// Single-port word RAM: synchronous write, registered read. The read
// register only loads on a read, so it holds the last load result.
module fpu_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Word write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  // Load a new read value only when a read completes.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fpu_mem_responder.sv
// FPU data-memory responder: accepts single-cycle read/write pulses, serves
// them from a word array after LATENCY cycles and returns a one-cycle ready.
// Optional macro FPU_MEM_RESP_JITTER_EN adds 0..3 LFSR-driven wait cycles.
module fpu_mem_responder
  import fpu_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_re,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        resp_busy,
  output logic [7:0]  drop_cnt
);

  localparam int                 AW     = $clog2(DEPTH);
  localparam logic [31:0]        SPAN   = 32'(4 * DEPTH);
  localparam logic [CNT_W-1:0]   LAT_M1 = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, wait_len;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  err_e              err_q, err_d, req_err;
  logic [7:0]        drop_q, drop_d;
  logic [31:0]       offset;
  logic              req, fire, ram_we, ram_re;
`ifdef FPU_MEM_RESP_JITTER_EN
  logic [7:0]        lfsr_q, lfsr_d;
`endif

  // Decode the incoming address; the subtract wraps so below-base is out of range.
  always_comb begin
    offset = mem_addr - BASE_ADDR;
    if (mem_re && mem_we)          req_err = ERR_BOTH_OP;
    else if (offset[1:0] != 2'b00) req_err = ERR_MISALIGN;
    else if (offset >= SPAN)       req_err = ERR_RANGE;
    else                           req_err = ERR_NONE;
  end

  // Next-state, request latching, drop counting and RAM strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    err_d    = err_q;
    drop_d   = drop_q;
    wait_len = LAT_M1;
    fire     = 1'b0;
    req      = mem_re | mem_we;
`ifdef FPU_MEM_RESP_JITTER_EN
    lfsr_d   = lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = offset[AW+1:2];
          wdata_d = mem_wdata;
          is_wr_d = mem_we;
          err_d   = req_err;
`ifdef FPU_MEM_RESP_JITTER_EN
          lfsr_d   = lfsr_step(lfsr_q);
          wait_len = LAT_M1 + CNT_W'(lfsr_d[1:0]);
`endif
          cnt_d = wait_len;
          if (wait_len == '0) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (req && state_q != ST_IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    // Commit on the edge entering RESP; a reset on that edge abandons it.
    ram_we = fire && is_wr_d && (err_d == ERR_NONE) && !rst;
    ram_re = fire && !is_wr_d && (err_d == ERR_NONE) && !rst;
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      err_q   <= ERR_NONE;
      drop_q  <= '0;
`ifdef FPU_MEM_RESP_JITTER_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
`ifdef FPU_MEM_RESP_JITTER_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  fpu_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_d),
    .wdata(wdata_d),
    .rdata(mem_rdata)
  );

  assign mem_ready = (state_q == ST_RESP);
  assign mem_err   = mem_ready && (err_q != ERR_NONE);
  assign resp_busy = (state_q != ST_IDLE);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fpu_mem_responder.sv
// Directed bench for fpu_mem_responder. Three instances: LATENCY=2 base 0,
// LATENCY=4 base 0x1000, LATENCY=1 base 0. Inputs are driven and outputs
// sampled on the falling edge.
module tb_fpu_mem_responder;

`ifdef FPU_MEM_RESP_JITTER_EN
  localparam bit JIT_EN = 1'b1;
`else
  localparam bit JIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_re    [3];
  logic        t_we    [3];
  logic [31:0] t_addr  [3];
  logic [31:0] t_wdata [3];
  logic [31:0] t_rdata [3];
  logic        t_ready [3];
  logic        t_err   [3];
  logic        t_busy  [3];
  logic [7:0]  t_drop  [3];
  logic [7:0]  mlfsr   [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fpu_mem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst(rst), .mem_addr(t_addr[0]), .mem_wdata(t_wdata[0]),
    .mem_re(t_re[0]), .mem_we(t_we[0]), .mem_rdata(t_rdata[0]), .mem_ready(t_ready[0]),
    .mem_err(t_err[0]), .resp_busy(t_busy[0]), .drop_cnt(t_drop[0]));

  fpu_mem_responder #(.DEPTH(256), .LATENCY(4), .BASE_ADDR(32'h0000_1000)) u_dut1 (
    .clk(clk), .rst(rst), .mem_addr(t_addr[1]), .mem_wdata(t_wdata[1]),
    .mem_re(t_re[1]), .mem_we(t_we[1]), .mem_rdata(t_rdata[1]), .mem_ready(t_ready[1]),
    .mem_err(t_err[1]), .resp_busy(t_busy[1]), .drop_cnt(t_drop[1]));

  fpu_mem_responder #(.DEPTH(256), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_dut2 (
    .clk(clk), .rst(rst), .mem_addr(t_addr[2]), .mem_wdata(t_wdata[2]),
    .mem_re(t_re[2]), .mem_we(t_we[2]), .mem_rdata(t_rdata[2]), .mem_ready(t_ready[2]),
    .mem_err(t_err[2]), .resp_busy(t_busy[2]), .drop_cnt(t_drop[2]));

  function automatic int lat_of(input int d);
    if (d == 0) return 2;
    if (d == 1) return 4;
    return 1;
  endfunction

  // Reference LFSR: Fibonacci, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int jit_of(input logic [7:0] s);
    return JIT_EN ? int'(s[1:0]) : 0;
  endfunction

  // Issue one accepted request and wait (bounded) for its ready.
  // Returns at the falling edge where ready is high; lat=-1 on timeout.
  task automatic do_req(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int exp_lat);
    @(negedge clk);
    t_re[d] = r; t_we[d] = w; t_addr[d] = a; t_wdata[d] = wd;
    mlfsr[d] = lfsr_next(mlfsr[d]);
    exp_lat = lat_of(d) + jit_of(mlfsr[d]);
    @(negedge clk);
    t_re[d] = 1'b0; t_we[d] = 1'b0;
    lat = 1;
    while (t_ready[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (t_ready[d] !== 1'b1) lat = -1;
  endtask

  // Accepted read on dut1 followed one cycle later by a second pulse.
  task automatic drop_pair(output int nready);
    nready = 0;
    @(negedge clk);
    t_re[1] = 1'b1; t_addr[1] = 32'h0000_1000;
    mlfsr[1] = lfsr_next(mlfsr[1]);
    @(negedge clk);
    nready += int'(t_ready[1]);
    @(negedge clk);
    t_re[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      nready += int'(t_ready[1]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_tests++; if (t_rdata[d] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata dut%0d got %h exp 0", d, t_rdata[d]); end
      n_tests++; if (t_ready[d] !== 1'b0) begin n_fail++; $display("FAIL rst_ready dut%0d got %b exp 0", d, t_ready[d]); end
      n_tests++; if (t_err[d] !== 1'b0) begin n_fail++; $display("FAIL rst_err dut%0d got %b exp 0", d, t_err[d]); end
      n_tests++; if (t_busy[d] !== 1'b0) begin n_fail++; $display("FAIL rst_busy dut%0d got %b exp 0", d, t_busy[d]); end
      n_tests++; if (t_drop[d] !== 8'd0) begin n_fail++; $display("FAIL rst_drop dut%0d got %0d exp 0", d, t_drop[d]); end
      mlfsr[d] = 8'hA5;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int lat, exp_lat;
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h3F80_0000, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL wr_lat got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_err[0] !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b exp 0", t_err[0]); end
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rd_lat got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_err[0] !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b exp 0", t_err[0]); end
    n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL rd_data got %h exp 3f800000", t_rdata[0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_tests++; if (t_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ready_pulse got %b exp 0", t_ready[0]); end
      end
      n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL rd_hold cyc%0d got %h exp 3f800000", i, t_rdata[0]); end
    end
  endtask

  task automatic test_errors;
    int lat, exp_lat;
    do_req(0, 1'b1, 1'b0, 32'h12, 32'h0, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL mis_lat got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_err[0] !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b exp 1", t_err[0]); end
    n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL mis_rdata got %h exp 3f800000", t_rdata[0]); end
    do_req(0, 1'b1, 1'b0, 32'h400, 32'h0, lat, exp_lat);
    n_tests++; if (t_err[0] !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b exp 1", t_err[0]); end
    n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL oor_rdata got %h exp 3f800000", t_rdata[0]); end
    do_req(0, 1'b0, 1'b1, 32'h11, 32'hDEAD_BEEF, lat, exp_lat);
    n_tests++; if (t_err[0] !== 1'b1) begin n_fail++; $display("FAIL miswr_err got %b exp 1", t_err[0]); end
    do_req(0, 1'b0, 1'b1, 32'h3FC, 32'h0000_03FC, lat, exp_lat);
    n_tests++; if (t_err[0] !== 1'b0) begin n_fail++; $display("FAIL top_wr_err got %b exp 0", t_err[0]); end
    do_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0, lat, exp_lat);
    n_tests++; if (t_rdata[0] !== 32'h0000_03FC) begin n_fail++; $display("FAIL top_rd got %h exp 000003fc", t_rdata[0]); end
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, exp_lat);
    n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL miswr_noeffect got %h exp 3f800000", t_rdata[0]); end
    // dut1 has base 0x1000: an address below base wraps out of range.
    do_req(1, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL wrap_lat got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_err[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_err got %b exp 1", t_err[1]); end
    do_req(1, 1'b0, 1'b1, 32'h0000_1000, 32'h5A5A_5A5A, lat, exp_lat);
    do_req(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, lat, exp_lat);
    n_tests++; if (t_err[1] !== 1'b0) begin n_fail++; $display("FAIL base_err got %b exp 0", t_err[1]); end
    n_tests++; if (t_rdata[1] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL base_rd got %h exp 5a5a5a5a", t_rdata[1]); end
  endtask

  task automatic test_both_ops;
    int lat, exp_lat;
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, lat, exp_lat);
    do_req(0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL both_lat got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_err[0] !== 1'b1) begin n_fail++; $display("FAIL both_err got %b exp 1", t_err[0]); end
    n_tests++; if (t_rdata[0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL both_rdata got %h exp 3f800000", t_rdata[0]); end
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, exp_lat);
    n_tests++; if (t_rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL both_word got %h exp 12345678", t_rdata[0]); end
  endtask

  task automatic test_drop;
    int nr;
    drop_pair(nr);
    n_tests++; if (nr !== 1) begin n_fail++; $display("FAIL drop_one_ready got %0d exp 1", nr); end
    n_tests++; if (t_drop[1] !== 8'd1) begin n_fail++; $display("FAIL drop_cnt1 got %0d exp 1", t_drop[1]); end
    for (int i = 2; i <= 300; i++) begin
      drop_pair(nr);
      if (i == 254) begin
        n_tests++; if (t_drop[1] !== 8'd254) begin n_fail++; $display("FAIL drop_cnt254 got %0d exp 254", t_drop[1]); end
      end
      if (i == 255) begin
        n_tests++; if (t_drop[1] !== 8'd255) begin n_fail++; $display("FAIL drop_cnt255 got %0d exp 255", t_drop[1]); end
      end
    end
    n_tests++; if (t_drop[1] !== 8'd255) begin n_fail++; $display("FAIL drop_sat got %0d exp 255", t_drop[1]); end
    n_tests++; if (nr !== 1) begin n_fail++; $display("FAIL drop_last_ready got %0d exp 1", nr); end
  endtask

  task automatic test_reset_mid;
    int lat, exp_lat, nr;
    do_req(0, 1'b0, 1'b1, 32'h30, 32'hAAAA_5555, lat, exp_lat);
    n_tests++; if (t_err[0] !== 1'b0) begin n_fail++; $display("FAIL mid_pre_err got %b exp 0", t_err[0]); end
    @(negedge clk);
    t_we[0] = 1'b1; t_addr[0] = 32'h30; t_wdata[0] = 32'h0BAD_F00D;
    @(negedge clk);
    t_we[0] = 1'b0;
    n_tests++; if (t_busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", t_busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) mlfsr[d] = 8'hA5;
    n_tests++; if (t_busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after got %b exp 0", t_busy[0]); end
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      nr += int'(t_ready[0]);
      @(negedge clk);
    end
    n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL mid_no_ready got %0d exp 0", nr); end
    n_tests++; if (t_drop[1] !== 8'd0) begin n_fail++; $display("FAIL mid_drop_clr got %0d exp 0", t_drop[1]); end
    do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, exp_lat);
    n_tests++; if (t_rdata[0] !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mid_word got %h exp aaaa5555", t_rdata[0]); end
  endtask

  task automatic test_jitter;
    int lat, exp_lat;
    do_req(2, 1'b0, 1'b1, 32'h40, 32'hCAFE_0001, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL l1_wr_lat got %0d exp %0d", lat, exp_lat); end
    for (int i = 0; i < 8; i++) begin
      do_req(2, 1'b1, 1'b0, 32'h40, 32'h0, lat, exp_lat);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL jit_lat rd%0d got %0d exp %0d", i, lat, exp_lat); end
      n_tests++; if ((lat >= 1 && lat <= 4) !== 1'b1) begin n_fail++; $display("FAIL jit_range rd%0d got %0d exp 1..4", i, lat); end
      n_tests++; if (t_rdata[2] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL jit_data rd%0d got %h exp cafe0001", i, t_rdata[2]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, exp_lat, nr;
    do_req(0, 1'b0, 1'b1, 32'h50, 32'h1111_1111, lat, exp_lat);
    do_req(0, 1'b1, 1'b0, 32'h50, 32'h0, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL b2b_lat1 got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_rdata[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rd1 got %h exp 11111111", t_rdata[0]); end
    do_req(0, 1'b0, 1'b1, 32'h54, 32'h2222_2222, lat, exp_lat);
    do_req(0, 1'b1, 1'b0, 32'h54, 32'h0, lat, exp_lat);
    n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL b2b_lat2 got %0d exp %0d", lat, exp_lat); end
    n_tests++; if (t_rdata[0] !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rd2 got %h exp 22222222", t_rdata[0]); end
    n_tests++; if (t_drop[0] !== 8'd0) begin n_fail++; $display("FAIL b2b_nodrop got %0d exp 0", t_drop[0]); end
    // A request presented during the RESP cycle is dropped.
    do_req(0, 1'b1, 1'b0, 32'h50, 32'h0, lat, exp_lat);
    t_re[0] = 1'b1; t_addr[0] = 32'h54;
    @(negedge clk);
    t_re[0] = 1'b0;
    n_tests++; if (t_drop[0] !== 8'd1) begin n_fail++; $display("FAIL resp_drop got %0d exp 1", t_drop[0]); end
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      nr += int'(t_ready[0]);
      @(negedge clk);
    end
    n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL resp_drop_ready got %0d exp 0", nr); end
    n_tests++; if (t_rdata[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL resp_drop_rdata got %h exp 11111111", t_rdata[0]); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      t_re[d] = 1'b0; t_we[d] = 1'b0; t_addr[d] = 32'h0; t_wdata[d] = 32'h0;
      mlfsr[d] = 8'hA5;
    end
    test_reset();
    test_write_read();
    test_errors();
    test_both_ops();
    test_drop();
    test_reset_mid();
    test_jitter();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
